// File: rtl/main_memory.sv
// Line-granular backing store below the cache: one READ/RFO/WRITE at a time,
// fixed-latency completion signalled by a one-cycle valid pulse.
module main_memory #(
    parameter int ADDRBITS  = 32,
    parameter int WORDBITS  = 32,
    parameter int LINEITEMS = 16,
    parameter int DEPTH     = 1024,
    parameter int LATENCY   = 4,
    parameter int LINE      = LINEITEMS * WORDBITS,
    parameter int IDXBITS   = $clog2(DEPTH)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                request,
    input  logic [1:0]          operation,
    input  logic [ADDRBITS-1:0] addr,
    input  logic [LINE-1:0]     d_in,
    output logic [LINE-1:0]     d_out,
    output logic                valid,
    output logic                busy,
    output logic                evict
);

    localparam int OFF     = $clog2(LINE / 8);
    localparam int CNTBITS = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] BUSY    = 2'd1;
    localparam logic [1:0] RESPOND = 2'd2;

    localparam logic [1:0] OP_NOP   = 2'd0;
    localparam logic [1:0] OP_WRITE = 2'd2;

    logic [LINE-1:0]    mem [DEPTH];
    logic [1:0]         state;
    logic [CNTBITS-1:0] cnt;
    logic [IDXBITS-1:0] idx_q;
    logic [1:0]         op_q;
    logic [LINE-1:0]    data_q;
    logic [IDXBITS-1:0] addr_idx;
    logic               commit_write;
    logic               unused_addr;

    // Offset and upper bits are dropped on purpose: lines alias modulo DEPTH.
    assign addr_idx    = addr[OFF+IDXBITS-1:OFF];
    assign unused_addr = ^{addr[ADDRBITS-1:OFF+IDXBITS], addr[OFF-1:0]};
    assign evict       = 1'b0;

    always_comb begin
        commit_write = (state == BUSY) && (cnt == '0) && (op_q == OP_WRITE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            d_out  <= '0;
            valid  <= 1'b0;
            busy   <= 1'b0;
            idx_q  <= '0;
            op_q   <= OP_NOP;
            data_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    valid <= 1'b0;
                    if (request && (operation != OP_NOP)) begin
                        idx_q <= addr_idx;
                        op_q  <= operation;
                        if (operation == OP_WRITE) begin
                            data_q <= d_in;
                        end
                        cnt   <= CNTBITS'(LATENCY - 1);
                        busy  <= 1'b1;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt == '0) begin
                        state <= RESPOND;
                        valid <= 1'b1;
                        if (op_q != OP_WRITE) begin
                            d_out <= mem[idx_q];
                        end
                    end else begin
                        cnt <= cnt - CNTBITS'(1);
                    end
                end
                RESPOND: begin
                    valid <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    valid <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Storage is never reset; an aborted write simply never reaches commit.
    always_ff @(posedge clock) begin
        if (commit_write) begin
            mem[idx_q] <= data_q;
        end
    end

endmodule

// File: tb/tb_main_memory.sv
// Directed, table-driven bench for main_memory: latency, data, aliasing,
// latched inputs, back-to-back requests, async reset abort and NOP handling.
module tb_main_memory;

    localparam int LAT  = 4;
    localparam int LINE = 512;

    localparam logic [1:0] NOP = 2'd0;
    localparam logic [1:0] RD  = 2'd1;
    localparam logic [1:0] WR  = 2'd2;
    localparam logic [1:0] RFO = 2'd3;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic            request = 1'b0;
    logic [1:0]      operation = 2'd0;
    logic [31:0]     addr = '0;
    logic [LINE-1:0] d_in = '0;
    logic [LINE-1:0] d_out;
    logic            valid;
    logic            busy;
    logic            evict;

    int n_checks = 0;
    int n_fail   = 0;

    main_memory #(.LATENCY(LAT)) dut (
        .clock(clock),
        .reset(reset),
        .request(request),
        .operation(operation),
        .addr(addr),
        .d_in(d_in),
        .d_out(d_out),
        .valid(valid),
        .busy(busy),
        .evict(evict)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]      op;
        logic [31:0]     a;
        logic [LINE-1:0] din;
        logic [LINE-1:0] exp;
        string           name;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [LINE-1:0] act, input logic [LINE-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_idle_outputs(input string name);
        check({name, " valid"}, LINE'(valid), LINE'(0));
        check({name, " busy"}, LINE'(busy), LINE'(0));
        check({name, " evict"}, LINE'(evict), LINE'(0));
    endtask

    task automatic run_txn(input logic [1:0] op, input logic [31:0] a,
                           input logic [LINE-1:0] din, input logic [LINE-1:0] exp,
                           input string name);
        int k;
        @(negedge clock);
        request = 1'b1; operation = op; addr = a; d_in = din;
        @(posedge clock); #1;
        check({name, " busy after accept"}, LINE'(busy), LINE'(1));
        request = 1'b0; operation = NOP; addr = 32'hFFFF_FFFF; d_in = '1;
        k = 0;
        while (!valid && k < 20) begin
            @(posedge clock); #1;
            k++;
        end
        check({name, " latency"}, LINE'(k), LINE'(LAT));
        check({name, " d_out"}, d_out, exp);
        @(posedge clock); #1;
        check({name, " valid single cycle"}, LINE'(valid), LINE'(0));
        check({name, " busy released"}, LINE'(busy), LINE'(0));
    endtask

    initial begin
        logic [LINE-1:0] dead, cafe, twos, pat, sevens;
        int k;
        dead   = {16{32'hDEADBEEF}};
        cafe   = {16{32'hCAFE0001}};
        twos   = {16{32'h22222222}};
        sevens = {16{32'h77770001}};
        for (int i = 0; i < 16; i++) pat[i*32 +: 32] = 32'h1000_0000 + 32'(i);

        vecs[0]  = '{WR,  32'h0000_0040, dead,   '0,   "wr line1"};
        vecs[1]  = '{RD,  32'h0000_0040, '0,     dead, "rd line1"};
        vecs[2]  = '{WR,  32'h0001_0040, cafe,   dead, "wr alias line1"};
        vecs[3]  = '{RD,  32'h0000_0040, '0,     cafe, "rd alias"};
        vecs[4]  = '{RD,  32'h0000_007C, '0,     cafe, "rd offset"};
        vecs[5]  = '{WR,  32'h0000_0080, twos,   cafe, "wr line2"};
        vecs[6]  = '{WR,  32'h0000_00C0, pat,    cafe, "wr line3"};
        vecs[7]  = '{RD,  32'h0000_00C0, '0,     pat,  "rd line3"};
        vecs[8]  = '{WR,  32'h0000_FFC0, sevens, pat,  "wr last line"};
        vecs[9]  = '{RD,  32'hFFFF_FFC0, '0,     sevens, "rd last alias"};
        vecs[10] = '{RFO, 32'h0000_0040, '0,     cafe, "rfo line1"};
        vecs[11] = '{RFO, 32'h0000_00C0, '0,     pat,  "rfo line3"};

        // Reset held from time 0, then idle with request low
        #2;
        check("reset d_out", d_out, '0);
        check_idle_outputs("reset");
        @(negedge clock); @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clock); #1;
            check("idle valid", LINE'(valid), LINE'(0));
            check("idle busy", LINE'(busy), LINE'(0));
        end

        for (int i = 0; i < 12; i++) begin
            run_txn(vecs[i].op, vecs[i].a, vecs[i].din, vecs[i].exp, vecs[i].name);
        end

        // Inputs changed during BUSY are ignored; held request starts a second txn
        @(negedge clock);
        request = 1'b1; operation = RD; addr = 32'h0000_0080; d_in = '0;
        @(posedge clock); #1;
        operation = RFO; addr = 32'h0000_0040; d_in = '1;
        k = 0;
        while (!valid && k < 20) begin
            @(posedge clock); #1;
            k++;
        end
        check("held first latency", LINE'(k), LINE'(LAT));
        check("held first d_out", d_out, twos);
        k = 0;
        do begin
            @(posedge clock); #1;
            k++;
            if (k == 2) begin
                check("held second accepted", LINE'(busy), LINE'(1));
                request = 1'b0; operation = NOP;
            end
        end while (!valid && k < 30);
        check("held second pulse spacing", LINE'(k), LINE'(LAT + 2));
        check("held second d_out", d_out, cafe);
        @(posedge clock); #1;
        check_idle_outputs("held end");

        // Asynchronous reset two cycles into a WRITE of line 5
        @(negedge clock);
        request = 1'b1; operation = WR; addr = 32'h0000_0140; d_in = {16{32'h5555AAAA}};
        @(posedge clock); #1;
        request = 1'b0; operation = NOP;
        @(posedge clock); @(posedge clock);
        #2 reset = 1'b1;
        #1;
        check("async reset d_out", d_out, '0);
        check_idle_outputs("async reset");
        @(negedge clock);
        reset = 1'b0;
        k = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clock); #1;
            if (valid) k++;
        end
        check("aborted write no valid", LINE'(k), LINE'(0));
        run_txn(RD, 32'h0000_0140, '0, '0, "rd line5 after abort");

        // NOP requests never start a transaction
        @(negedge clock);
        request = 1'b1; operation = NOP; addr = 32'h0000_0040; d_in = '1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #1;
            check("nop busy", LINE'(busy), LINE'(0));
            check("nop valid", LINE'(valid), LINE'(0));
        end
        request = 1'b0;
        check("nop d_out unchanged", d_out, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
